// File: rtl/model_cpu_div_pkg.sv
// Shared types and constants for the iterative CPU divider.
package model_cpu_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_ITERS  = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_ITERS);

  localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/model_cpu_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module model_cpu_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] dvd,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] dvd_next,
  output logic         q_bit
);

  logic [W+1:0] trial;

  // One extra bit above the 33-bit remainder exposes the borrow as a sign bit.
  always_comb begin
    trial    = {rem, dvd[W-1]} - {2'b00, divisor};
    q_bit    = ~trial[W+1];
    rem_next = q_bit ? trial[W:0] : {rem[W-1:0], dvd[W-1]};
    dvd_next = {dvd[W-2:0], 1'b0};
  end

endmodule

// File: rtl/model_cpu_div_cell.sv
// Iterative 32-bit signed/unsigned divider returning quotient or remainder, one quotient bit per clock.
module model_cpu_div_cell
  import model_cpu_div_pkg::*;
#(
  parameter int DATA_W       = DIV_DATA_W,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              E_div_rem,
  input  logic              D_div_kill,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_result
);

  div_state_t state, state_next;

  logic [DATA_W:0]       rem_q;
  logic [DATA_W-1:0]     dvd_q, dsr_q, quot_q;
  logic                  sgn_q, rem_sel_q, q_neg_q, r_neg_q;
  logic [DIV_CNT_W-1:0]  count_q;

  logic [DATA_W:0]       rem_step;
  logic [DATA_W-1:0]     dvd_step;
  logic                  q_bit;

  logic                  special;
  logic [DATA_W-1:0]     special_result, quot_fix, rem_fix;

  model_cpu_div_step #(.W(DATA_W)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dsr_q),
    .rem_next (rem_step),
    .dvd_next (dvd_step),
    .q_bit    (q_bit)
  );

  // In PREP the operand registers still hold the raw latched values.
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (dsr_q == '0) begin
      special        = FAST_SPECIAL;
      special_result = rem_sel_q ? dvd_q : DIV0_QUOT;
    end else if (sgn_q && dvd_q == SIGNED_MIN && dsr_q == '1) begin
      special        = FAST_SPECIAL;
      special_result = rem_sel_q ? '0 : SIGNED_MIN;
    end
    quot_fix = q_neg_q ? -quot_q : quot_q;
    rem_fix  = r_neg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (E_div_start && !D_div_kill) state_next = PREP;
      PREP:    state_next = special ? DONE : ITER;
      ITER:    if (count_q == DIV_CNT_W'(DIV_ITERS - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (D_div_kill && state != IDLE) state_next = IDLE;
  end

  always_comb begin
    M_div_busy = (state == PREP) || (state == ITER) || (state == FIX);
    M_div_done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q        <= '0;
      dvd_q        <= '0;
      dsr_q        <= '0;
      quot_q       <= '0;
      sgn_q        <= 1'b0;
      rem_sel_q    <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      count_q      <= '0;
      M_div_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (E_div_start && !D_div_kill) begin
            dvd_q     <= E_src1;
            dsr_q     <= E_src2;
            sgn_q     <= E_div_signed;
            rem_sel_q <= E_div_rem;
          end
        end
        PREP: begin
          dvd_q   <= (sgn_q && dvd_q[DATA_W-1]) ? -dvd_q : dvd_q;
          dsr_q   <= (sgn_q && dsr_q[DATA_W-1]) ? -dsr_q : dsr_q;
          q_neg_q <= sgn_q & (dvd_q[DATA_W-1] ^ dsr_q[DATA_W-1]);
          r_neg_q <= sgn_q & dvd_q[DATA_W-1];
          rem_q   <= '0;
          quot_q  <= '0;
          count_q <= '0;
          if (special && !D_div_kill) M_div_result <= special_result;
        end
        ITER: begin
          rem_q   <= rem_step;
          dvd_q   <= dvd_step;
          quot_q  <= {quot_q[DATA_W-2:0], q_bit};
          count_q <= count_q + DIV_CNT_W'(1);
        end
        FIX: begin
          if (!D_div_kill) M_div_result <= rem_sel_q ? rem_fix : quot_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_model_cpu_div_cell.sv
// Self-checking bench for model_cpu_div_cell: directed vectors plus a per-cycle behavioural model.
module tb_model_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] E_src1, E_src2;
  logic        E_div_start, E_div_signed, E_div_rem, D_div_kill;
  logic        M_div_busy, M_div_done;
  logic [31:0] M_div_result;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  model_cpu_div_cell #(.DATA_W(32), .FAST_SPECIAL(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .E_div_rem    (E_div_rem),
    .D_div_kill   (D_div_kill),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_result (M_div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_special(input logic [31:0] a, b, input logic s);
    return (b == 32'd0) || (s && a == MIN32 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, b, input logic s, r);
    logic [31:0] q, m;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; m = a;
    end else if (s && a == MIN32 && b == 32'hFFFF_FFFF) begin
      q = MIN32; m = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      m = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; m = a % b;
    end
    return r ? m : q;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Cycle-level model: tracks one outstanding operation by its start cycle and latency.
  bit          act = 1'b0, armed = 1'b0;
  int          t0 = 0, lat = 0;
  logic [31:0] res_new = '0, held = '0;
  bit          p_rst = 1'b1, p_start = 1'b0, p_kill = 1'b0, p_sgn = 1'b0, p_rem = 1'b0;
  logic [31:0] p_s1 = '0, p_s2 = '0;

  always @(negedge clk) begin
    bit was_idle;
    bit eb, ed;
    int rel;
    was_idle = !act;
    if (!p_rst) begin
      act = 1'b0; held = '0; armed = 1'b1;
    end else if (was_idle) begin
      if (p_start && !p_kill) begin
        t0      = cyc - 1;
        lat     = is_special(p_s1, p_s2, p_sgn) ? 2 : 35;
        res_new = ref_div(p_s1, p_s2, p_sgn, p_rem);
        act     = 1'b1;
      end
    end else if (p_kill || (cyc - t0) > lat) begin
      act = 1'b0;
    end
    rel = cyc - t0;
    eb  = act && rel < lat;
    ed  = act && rel == lat;
    if (ed) held = res_new;
    if (armed) begin
      check("model_busy", {31'd0, M_div_busy}, {31'd0, eb});
      check("model_done", {31'd0, M_div_done}, {31'd0, ed});
      check("model_result", M_div_result, held);
    end
    p_rst = reset_n; p_start = E_div_start; p_kill = D_div_kill;
    p_sgn = E_div_signed; p_rem = E_div_rem; p_s1 = E_src1; p_s2 = E_src2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    E_div_start = 1'b0;
    D_div_kill  = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, b, input logic s, r);
    E_src1 = a; E_src2 = b; E_div_signed = s; E_div_rem = r; E_div_start = 1'b1;
  endtask

  task automatic wait_done(input string name, input int c0, input int eo,
                           input logic [31:0] ev, input int eb);
    bit found;
    int nb;
    found = 1'b0;
    nb = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (M_div_done === 1'b1) found = 1'b1;
      else if (M_div_busy === 1'b1) nb++;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 80 cycles, required at cycle %0d", name, eo);
    end else begin
      check_int({name, "_done_cycle"}, cyc - c0, eo);
      check({name, "_result"}, M_div_result, ev);
      if (eb >= 0) check_int({name, "_busy_cycles"}, nb, eb);
    end
    tick();
  endtask

  task automatic run_op(input string name, input logic [31:0] a, b, input logic s, r,
                        input logic [31:0] ev, input int eo);
    int c0;
    drive(a, b, s, r);
    c0 = cyc;
    tick();
    wait_done(name, c0, eo, ev, eo - 1);
  endtask

  initial begin
    int c0;
    logic [31:0] a, b;
    logic s, r;
    int sel;

    reset_n = 1'b0;
    E_src1 = '0; E_src2 = '0;
    E_div_start = 1'b0; E_div_signed = 1'b0; E_div_rem = 1'b0; D_div_kill = 1'b0;
    repeat (3) tick();
    check("reset_busy", {31'd0, M_div_busy}, 32'd0);
    check("reset_done", {31'd0, M_div_done}, 32'd0);
    check("reset_result", M_div_result, 32'd0);
    reset_n = 1'b1;
    tick();

    check("ref_u_100_7_q", ref_div(32'd100, 32'd7, 1'b0, 1'b0), 32'h0000_000E);
    check("ref_s_m7_2_r", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1), 32'hFFFF_FFFF);
    check("ref_s_min_m1_q", ref_div(MIN32, 32'hFFFF_FFFF, 1'b1, 1'b0), MIN32);

    run_op("u_100_7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 35);
    run_op("u_100_7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'h0000_0002, 35);
    run_op("s_m7_2_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 35);
    run_op("s_m7_2_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 35);
    run_op("s_7_m2_q", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 35);
    run_op("s_7_m2_r", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0001, 35);
    run_op("u_5_0_q", 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 2);
    run_op("u_5_0_r", 32'd5, 32'd0, 1'b0, 1'b1, 32'h0000_0005, 2);
    run_op("s_min_m1_q", MIN32, 32'hFFFF_FFFF, 1'b1, 1'b0, MIN32, 2);
    run_op("s_min_m1_r", MIN32, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 2);

    // Kill in cycle 10, restart in cycle 11.
    run_op("pre_kill", 32'd100, 32'd7, 1'b0, 1'b0, 32'h0000_000E, 35);
    drive(32'h0000_1234, 32'd3, 1'b0, 1'b0);
    c0 = cyc;
    tick();
    repeat (9) tick();
    D_div_kill = 1'b1;
    tick();
    drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    @(negedge clk);
    check("kill_busy", {31'd0, M_div_busy}, 32'd0);
    check("kill_done", {31'd0, M_div_done}, 32'd0);
    check("kill_result_held", M_div_result, 32'h0000_000E);
    tick();
    wait_done("kill_restart", c0, 46, 32'hFFFF_FFFF, -1);

    // Start pulsed again mid-operation must be ignored.
    drive(32'd1000, 32'd10, 1'b0, 1'b0);
    c0 = cyc;
    tick();
    repeat (4) tick();
    drive(32'd7, 32'd7, 1'b1, 1'b1);
    tick();
    wait_done("restart_ignored", c0, 35, 32'd100, -1);

    // Start and kill together in IDLE: dropped.
    drive(32'd9, 32'd3, 1'b0, 1'b0);
    D_div_kill = 1'b1;
    tick();
    check("startkill_busy", {31'd0, M_div_busy}, 32'd0);
    tick();
    check("startkill_busy2", {31'd0, M_div_busy}, 32'd0);
    check("startkill_result", M_div_result, 32'd100);

    // Reset in cycle 20 of an operation.
    drive(32'd50, 32'd5, 1'b0, 1'b0);
    tick();
    repeat (19) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_busy", {31'd0, M_div_busy}, 32'd0);
    check("midreset_done", {31'd0, M_div_done}, 32'd0);
    check("midreset_result", M_div_result, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int k = 0; k < 200; k++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      s   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) b = -b;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = MIN32; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 9));
      run_op("rand", a, b, s, r, ref_div(a, b, s, r), is_special(a, b, s) ? 2 : 35);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
